// File: rtl/elevator_request_unit_if.sv
// Purpose: board/FSM-facing signal bundle of the elevator request unit.
// Ports  : key_n, hall_sw, cur_floor, at_rest, serve (towards the unit);
//          pending, req_valid, target, dir_up, here (from the unit).
//          master = board + controller FSM side, slave = request unit side.
interface elevator_request_unit_if #(
  parameter int FLOORS = 4,
  parameter int FW     = 2
);
  logic [FLOORS-1:0] key_n;
  logic [FLOORS-1:0] hall_sw;
  logic [FW-1:0]     cur_floor;
  logic              at_rest;
  logic              serve;
  logic [FLOORS-1:0] pending;
  logic              req_valid;
  logic [FW-1:0]     target;
  logic              dir_up;
  logic              here;

  modport master (
    output key_n, hall_sw, cur_floor, at_rest, serve,
    input  pending, req_valid, target, dir_up, here
  );

  modport slave (
    input  key_n, hall_sw, cur_floor, at_rest, serve,
    output pending, req_valid, target, dir_up, here
  );
endinterface

// File: rtl/elevator_request_unit.sv
// Purpose: captures cabin/hall requests into a pending bitmap and hands the
//          controller FSM a scan-ordered target floor and direction.
// Latency: press -> pending 3 edges; pending/cur_floor -> target/dir/here 1 edge.
// Backpressure: none; requests accumulate in the bitmap until served.
// Ports  : CLOCK_50, reset (async, active-high), bus (slave side of
//          elevator_request_unit_if).
module elevator_request_unit #(
  parameter int FLOORS = 4,
  parameter int FW     = 2
) (
  input  logic                    CLOCK_50,
  input  logic                    reset,
  elevator_request_unit_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_UP   = 2'd1,
    S_DOWN = 2'd2
  } state_t;

  // input synchronizers and edge-detect history
  logic [FLOORS-1:0] r_key_s1, r_key_s2, r_key_prev;
  logic [FLOORS-1:0] r_hall_s1, r_hall_s2, r_hall_prev;

  logic [FLOORS-1:0] r_pending;
  state_t            r_state;
  logic              r_dir_up;
  logic [FW-1:0]     r_target;
  logic              r_req_valid;
  logic              r_here;

  logic [FLOORS-1:0] w_evt;
  logic [FLOORS-1:0] w_clr;
  logic [FLOORS-1:0] w_pending_nxt;
  logic              w_any;
  logic              w_here_now;
  logic              w_has_above, w_has_below;
  logic [FW-1:0]     w_lo_above, w_hi_below;
  logic              w_go_up;
  state_t            w_state_nxt;
  logic              w_dir_nxt;
  logic [FW-1:0]     w_target_nxt;

  // rising edge of a synchronized level is a request; held levels are not
  assign w_evt = (r_key_s2 & ~r_key_prev) | (r_hall_s2 & ~r_hall_prev);

  // clear mask applied after set so a same-floor set/serve collision drops
  assign w_clr         = bus.serve ? (FLOORS'(1) << bus.cur_floor) : '0;
  assign w_pending_nxt = (r_pending | w_evt) & ~w_clr;

  assign w_any      = |r_pending;
  assign w_here_now = r_pending[bus.cur_floor];

  // nearest pending floor strictly above / strictly below cur_floor
  always_comb begin
    w_has_above = 1'b0;
    w_has_below = 1'b0;
    w_lo_above  = '0;
    w_hi_below  = '0;
    for (int i = FLOORS - 1; i >= 0; i--) begin
      if (r_pending[i] && (i > int'(bus.cur_floor))) begin
        w_has_above = 1'b1;
        w_lo_above  = FW'(i);
      end
    end
    for (int i = 0; i < FLOORS; i++) begin
      if (r_pending[i] && (i < int'(bus.cur_floor))) begin
        w_has_below = 1'b1;
        w_hi_below  = FW'(i);
      end
    end
  end

  // from rest, head for the closer side; a tie goes up
  assign w_go_up = w_has_above &&
                   (!w_has_below ||
                    ((w_lo_above - bus.cur_floor) <= (bus.cur_floor - w_hi_below)));

  always_comb begin
    w_state_nxt = r_state;
    w_dir_nxt   = r_dir_up;
    if (bus.at_rest) begin
      case (r_state)
        S_IDLE: begin
          if (w_any && !w_here_now) begin
            w_state_nxt = w_go_up ? S_UP : S_DOWN;
          end
        end
        S_UP: begin
          if (!w_any) begin
            w_state_nxt = S_IDLE;
          end else if (!w_has_above && w_has_below) begin
            w_state_nxt = S_DOWN;
          end
        end
        S_DOWN: begin
          if (!w_any) begin
            w_state_nxt = S_IDLE;
          end else if (!w_has_below && w_has_above) begin
            w_state_nxt = S_UP;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
    if (w_state_nxt == S_UP) begin
      w_dir_nxt = 1'b1;
    end else if (w_state_nxt == S_DOWN) begin
      w_dir_nxt = 1'b0;
    end
  end

  // target follows the scan direction; when the preferred side is empty
  // (e.g. moving with at_rest low) it falls back to the other side
  always_comb begin
    w_target_nxt = bus.cur_floor;
    if (w_any && !w_here_now) begin
      case (w_state_nxt)
        S_UP:    w_target_nxt = w_has_above ? w_lo_above : w_hi_below;
        S_DOWN:  w_target_nxt = w_has_below ? w_hi_below : w_lo_above;
        default: w_target_nxt = w_go_up ? w_lo_above : w_hi_below;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_key_s1    <= '0;
      r_key_s2    <= '0;
      r_key_prev  <= '0;
      r_hall_s1   <= '0;
      r_hall_s2   <= '0;
      r_hall_prev <= '0;
      r_pending   <= '0;
      r_state     <= S_IDLE;
      r_dir_up    <= 1'b1;
      r_target    <= '0;
      r_req_valid <= 1'b0;
      r_here      <= 1'b0;
    end else begin
      r_key_s1    <= ~bus.key_n;
      r_key_s2    <= r_key_s1;
      r_key_prev  <= r_key_s2;
      r_hall_s1   <= bus.hall_sw;
      r_hall_s2   <= r_hall_s1;
      r_hall_prev <= r_hall_s2;
      r_pending   <= w_pending_nxt;
      r_state     <= w_state_nxt;
      r_dir_up    <= w_dir_nxt;
      r_target    <= w_target_nxt;
      r_req_valid <= w_any;
      r_here      <= w_here_now;
    end
  end

  assign bus.pending   = r_pending;
  assign bus.req_valid = r_req_valid;
  assign bus.target    = r_target;
  assign bus.dir_up    = r_dir_up;
  assign bus.here      = r_here;

endmodule

// File: tb/tb_elevator_request_unit.sv
// Purpose: directed self-checking bench for elevator_request_unit.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_elevator_request_unit;

  logic CLOCK_50;
  logic reset;
  int   n_cmp;
  int   n_err;

  elevator_request_unit_if #(.FLOORS(4), .FW(2)) bus ();

  elevator_request_unit #(.FLOORS(4), .FW(2)) dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .bus      (bus)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // advance n rising edges, land 1 ns after the last one
  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge CLOCK_50);
      #1;
    end
  endtask

  // one-cycle button pulse; returns right after the edge that sets pending
  task automatic press(input logic [3:0] kn, input logic [3:0] hs);
    bus.key_n   = kn;
    bus.hall_sw = hs;
    tick(1);
    bus.key_n   = 4'b1111;
    bus.hall_sw = 4'b0000;
    tick(2);
  endtask

  // FSM arrives at floor f and opens doors; outputs then reflect the clear
  task automatic serve_at(input logic [1:0] f);
    bus.cur_floor = f;
    bus.serve     = 1'b1;
    tick(1);
    bus.serve     = 1'b0;
    tick(1);
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, ".pending"},   int'(bus.pending),   0);
    check_eq({tag, ".req_valid"}, int'(bus.req_valid), 0);
    check_eq({tag, ".target"},    int'(bus.target),    0);
    check_eq({tag, ".dir_up"},    int'(bus.dir_up),    1);
    check_eq({tag, ".here"},      int'(bus.here),      0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    bus.key_n     = 4'b1111;
    bus.hall_sw   = 4'b0000;
    bus.cur_floor = 2'd0;
    bus.at_rest   = 1'b1;
    bus.serve     = 1'b0;
    reset = 1'b0;
    #1 reset = 1'b1;
    #20;
    check_reset_vals("rst0");
    @(negedge CLOCK_50);
    reset = 1'b0;
    tick(2);

    // 1: cabin floor 2 + hall floor 1 in the same cycle, from floor 0
    bus.key_n   = 4'b1011;
    bus.hall_sw = 4'b0010;
    tick(1);
    bus.key_n   = 4'b1111;
    bus.hall_sw = 4'b0000;
    tick(1);
    check_eq("t1.lat_edge2", int'(bus.pending), 0);
    tick(1);
    check_eq("t1.pending_edge3", int'(bus.pending), 4'b0110);
    tick(1);
    check_eq("t1.target", int'(bus.target), 1);
    check_eq("t1.dir_up", int'(bus.dir_up), 1);
    check_eq("t1.req_valid", int'(bus.req_valid), 1);
    serve_at(2'd1);
    check_eq("t1.pending_srv", int'(bus.pending), 4'b0100);
    check_eq("t1.target_srv", int'(bus.target), 2);
    serve_at(2'd2);
    check_eq("t1.req_valid_end", int'(bus.req_valid), 0);
    check_eq("t1.target_end", int'(bus.target), 2);

    // 2: equal-distance tie from floor 1 goes up
    bus.cur_floor = 2'd1;
    press(4'b1111, 4'b0101);
    check_eq("t2.pending", int'(bus.pending), 4'b0101);
    tick(1);
    check_eq("t2.target", int'(bus.target), 2);
    check_eq("t2.dir_up", int'(bus.dir_up), 1);
    serve_at(2'd2);
    check_eq("t2.target_dn", int'(bus.target), 0);
    check_eq("t2.dir_dn", int'(bus.dir_up), 0);
    serve_at(2'd0);
    check_eq("t2.req_valid_end", int'(bus.req_valid), 0);

    // 3: both ends from floor 2
    bus.cur_floor = 2'd2;
    press(4'b1111, 4'b1001);
    tick(1);
    check_eq("t3.target", int'(bus.target), 3);
    check_eq("t3.dir_up", int'(bus.dir_up), 1);
    serve_at(2'd3);
    check_eq("t3.target_dn", int'(bus.target), 0);
    check_eq("t3.dir_dn", int'(bus.dir_up), 0);
    serve_at(2'd0);
    check_eq("t3.req_valid_end", int'(bus.req_valid), 0);
    check_eq("t3.dir_held", int'(bus.dir_up), 0);

    // 4: same-floor request, cabin + hall together
    bus.cur_floor = 2'd1;
    press(4'b1101, 4'b0010);
    check_eq("t4.pending", int'(bus.pending), 4'b0010);
    tick(1);
    check_eq("t4.here", int'(bus.here), 1);
    check_eq("t4.target", int'(bus.target), 1);
    bus.serve = 1'b1;
    tick(1);
    bus.serve = 1'b0;
    check_eq("t4.pending_clr", int'(bus.pending), 0);
    check_eq("t4.here_lag", int'(bus.here), 1);
    tick(1);
    check_eq("t4.here_drop", int'(bus.here), 0);

    // 5: set/clear collision on floor 2, then a held switch on floor 3
    bus.cur_floor = 2'd2;
    bus.hall_sw   = 4'b0100;
    tick(2);
    bus.serve = 1'b1;
    tick(1);
    bus.serve = 1'b0;
    check_eq("t5.collision", int'(bus.pending), 0);
    bus.hall_sw = 4'b0000;
    tick(3);
    bus.hall_sw = 4'b1000;
    tick(103);
    check_eq("t5.hold_one", int'(bus.pending), 4'b1000);
    serve_at(2'd3);
    tick(5);
    check_eq("t5.hold_no_repeat", int'(bus.pending), 0);
    bus.hall_sw = 4'b0000;
    tick(3);

    // 6: direction lock while moving
    bus.cur_floor = 2'd1;
    press(4'b1111, 4'b0100);
    tick(1);
    check_eq("t6.dir_up", int'(bus.dir_up), 1);
    bus.at_rest = 1'b0;
    press(4'b1111, 4'b0001);
    serve_at(2'd2);
    check_eq("t6.pending", int'(bus.pending), 4'b0001);
    tick(3);
    check_eq("t6.locked_up", int'(bus.dir_up), 1);
    check_eq("t6.target_moving", int'(bus.target), 0);
    bus.at_rest = 1'b1;
    tick(1);
    check_eq("t6.reversed", int'(bus.dir_up), 0);
    serve_at(2'd0);

    // 7: reset mid-run with pending 1001, key held through release
    bus.cur_floor = 2'd1;
    press(4'b1111, 4'b1001);
    check_eq("t7.pending_pre", int'(bus.pending), 4'b1001);
    tick(1);
    #2 reset = 1'b1;
    #1;
    check_reset_vals("t7.async");
    bus.key_n = 4'b0111;
    tick(3);
    check_eq("t7.in_reset", int'(bus.pending), 0);
    reset = 1'b0;
    tick(3);
    check_eq("t7.one_event", int'(bus.pending), 4'b1000);
    tick(50);
    check_eq("t7.still_one", int'(bus.pending), 4'b1000);
    bus.key_n = 4'b1111;
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
